ext_irq_ctrl: RTL

External interrupt controller that drives the processor's `ExtIRQ` input and consumes its `ExtIAck` acknowledge. It edge-detects several device interrupt lines, latches them as pending, and presents one request at a time using fixed lowest-index-first priority. It holds `ExtIRQ` until the core acknowledges, then clears the serviced source. It sits beside `processor_arm` at the top level, on the device side of the interrupt handshake.

---
 rtl/arm_irq_pkg.sv | 13 +
 rtl/ext_irq_ctrl_if.sv | 37 +++
 rtl/prio_enc.sv | 22 ++
 rtl/ext_irq_ctrl.sv | 118 +++++++++++
 4 files changed

// File: rtl/arm_irq_pkg.sv
// Shared types and constants for the external interrupt controller.
package arm_irq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    ACKED,
    GAP
  } irq_state_t;

  localparam int unsigned IRQ_MIN_GAP_DEFAULT = 2;

endpackage

// File: rtl/ext_irq_ctrl_if.sv
// Device-side interrupt bundle between the controller, the interrupt sources and the core.
interface ext_irq_ctrl_if #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = $clog2(N_SRC)
);

  logic [N_SRC-1:0] irq_src;
  logic [N_SRC-1:0] irq_mask;
  logic             ExtIAck;
  logic             ExtIRQ;
  logic [ID_W-1:0]  irq_id;
  logic [N_SRC-1:0] pending;
  logic             busy;

  // Controller side.
  modport master (
    input  irq_src,
    input  irq_mask,
    input  ExtIAck,
    output ExtIRQ,
    output irq_id,
    output pending,
    output busy
  );

  // Sources and core side.
  modport slave (
    output irq_src,
    output irq_mask,
    output ExtIAck,
    input  ExtIRQ,
    input  irq_id,
    input  pending,
    input  busy
  );

endinterface

// File: rtl/prio_enc.sv
// Lowest-index-first priority encoder.
module prio_enc #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned ID_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  output logic             valid,
  output logic [ID_W-1:0]  idx
);

  always_comb begin
    valid = |req;
    idx   = '0;
    // Scan downwards so the lowest set index is the last one written.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/ext_irq_ctrl.sv
// External interrupt controller: edge-latches device lines and presents one
// request at a time to the core over the ExtIRQ/ExtIAck handshake.
module ext_irq_ctrl
  import arm_irq_pkg::*;
#(
  parameter int unsigned N_SRC   = 4,
  parameter int unsigned ID_W    = $clog2(N_SRC),
  parameter int unsigned MIN_GAP = IRQ_MIN_GAP_DEFAULT
) (
  input logic            clk,
  input logic            reset,
  ext_irq_ctrl_if.master irq
);

  localparam int unsigned CNT_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

  if (N_SRC < 2 || N_SRC > 16) begin : gen_bad_n_src
    $error("ext_irq_ctrl: N_SRC must be in 2..16");
  end
  if (MIN_GAP < 1) begin : gen_bad_min_gap
    $error("ext_irq_ctrl: MIN_GAP must be at least 1");
  end

  irq_state_t       state_q, state_d;
  logic [N_SRC-1:0] src_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] src_edge;
  logic [N_SRC-1:0] issuable;
  logic [N_SRC-1:0] clr;
  logic             irq_q, irq_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             win_valid;
  logic [ID_W-1:0]  win_idx;

  assign src_edge = irq.irq_src & ~src_q;
  assign issuable = pending_q & ~irq.irq_mask;

  prio_enc #(
    .N_SRC (N_SRC),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .req   (issuable),
    .valid (win_valid),
    .idx   (win_idx)
  );

  always_comb begin
    state_d = state_q;
    irq_d   = irq_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    clr     = '0;
    unique case (state_q)
      IDLE: begin
        if (win_valid) begin
          id_d    = win_idx;
          irq_d   = 1'b1;
          state_d = REQ;
        end
      end
      // Mask changes are ignored here: an issued request is never withdrawn.
      REQ: begin
        if (irq.ExtIAck) begin
          clr[id_q] = 1'b1;
          irq_d     = 1'b0;
          state_d   = ACKED;
        end
      end
      ACKED: begin
        if (!irq.ExtIAck) begin
          cnt_d   = CNT_W'(MIN_GAP - 1);
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // A fresh edge beats the acknowledge clear on the same bit.
    pending_d = (pending_q & ~clr) | src_edge;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      // Track the live lines so a source already high at release is not an edge.
      src_q     <= irq.irq_src;
      pending_q <= '0;
      irq_q     <= 1'b0;
      id_q      <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      src_q     <= irq.irq_src;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      id_q      <= id_d;
      cnt_q     <= cnt_d;
    end
  end

  assign irq.ExtIRQ  = irq_q;
  assign irq.irq_id  = id_q;
  assign irq.pending = pending_q;
  assign irq.busy    = (state_q != IDLE);

  a_req_in_req_state : assert property (@(posedge clk) disable iff (reset)
    irq_q |-> (state_q == REQ));
  a_req_is_pending : assert property (@(posedge clk) disable iff (reset)
    irq_q |-> pending_q[id_q]);

endmodule
